ascon_in_loader: RTL and testbench

ASCON_IN_LOADER -- requirements
Module: ascon_in_loader

---
 rtl/ascon_loader_pkg.sv | 24 ++
 rtl/ascon_field_shreg.sv | 28 ++
 rtl/ascon_in_loader.sv | 148 ++++++++++++++
 tb/tb_ascon_in_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_loader_pkg.sv
// Shared types and constants for the Ascon input loader.
// Holds the FSM state type, the field index map (SK, N, A, P) and
// the words-per-field helper used to size the word counter.
package ascon_loader_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int unsigned FIELD_W = 128;
  localparam int unsigned NUM_FLD = 4;

  localparam int unsigned FLD_SK = 0;
  localparam int unsigned FLD_N  = 1;
  localparam int unsigned FLD_A  = 2;
  localparam int unsigned FLD_P  = 3;

  // Number of bus words that make up one 128-bit field.
  function automatic int unsigned wpf(input int unsigned bus_w);
    return FIELD_W / bus_w;
  endfunction

endpackage

// File: rtl/ascon_field_shreg.sv
// 128-bit shift-load register for one loader field.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (clears to zero)
//   en       : shift one bus word in this cycle
//   din      : bus word, becomes the least-significant word
//   q        : field contents, first word loaded ends up most significant
module ascon_field_shreg
  import ascon_loader_pkg::*;
#(
  parameter int unsigned BUS_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [BUS_W-1:0]   din,
  output logic [FIELD_W-1:0] q
);

  // Shift left by one word; with BUS_W = 128 the old contents shift out entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= (q << BUS_W) | FIELD_W'(din);
    end
  end

endmodule

// File: rtl/ascon_in_loader.sv
// Ascon input loader: collects BUS_W-bit words into the 128-bit SK, N, A
// and P fields and presents them as one frame to the encryption core.
// Ports:
//   CLK, RST             : clock, asynchronous active-high reset
//   DIN, IN_VALID        : input word stream
//   IN_READY             : high while filling (decoded from state only)
//   KEY_KEEP             : reuse stored key for this frame (ASCON_LOADER_KEY_REUSE_EN only)
//   SK_OUT/N_OUT/A_OUT/P_OUT : assembled fields
//   OUT_VALID, OUT_READY : frame handshake toward the core
// Optional feature: define ASCON_LOADER_KEY_REUSE_EN to add KEY_KEEP and key reuse.
module ascon_in_loader
  import ascon_loader_pkg::*;
#(
  parameter int unsigned BUS_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BUS_W-1:0]   DIN,
  input  logic               IN_VALID,
  output logic               IN_READY,
`ifdef ASCON_LOADER_KEY_REUSE_EN
  input  logic               KEY_KEEP,
`endif
  output logic [FIELD_W-1:0] SK_OUT,
  output logic [FIELD_W-1:0] N_OUT,
  output logic [FIELD_W-1:0] A_OUT,
  output logic [FIELD_W-1:0] P_OUT,
  output logic               OUT_VALID,
  input  logic               OUT_READY
);

  localparam int unsigned WPF    = wpf(BUS_W);
  localparam int unsigned NWORDS = NUM_FLD * WPF;
  localparam int unsigned CNT_W  = $clog2(NWORDS);
  localparam int unsigned SEL_SH = $clog2(WPF);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               xfer;
  logic               last_word;
  logic               skip_key;
  logic [1:0]         fld_sel;
  logic [NUM_FLD-1:0] fld_en;
  logic [FIELD_W-1:0] fld_q [NUM_FLD];
  logic               in_ready_c;
  logic               out_valid_c;

  assign xfer      = IN_VALID && (state == ST_FILL);
  assign last_word = (cnt == CNT_W'(NWORDS - 1));

`ifdef ASCON_LOADER_KEY_REUSE_EN
  logic key_loaded;

  // A kept key turns word 0 into N word 0 once a key has been loaded.
  assign skip_key = (cnt == '0) && KEY_KEEP && key_loaded;

  // Key becomes reusable once its last word has been shifted in.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_loaded <= 1'b0;
    end else if (xfer && (cnt == CNT_W'(WPF - 1))) begin
      key_loaded <= 1'b1;
    end
  end
`else
  assign skip_key = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (xfer && last_word) state_nxt = ST_HOLD;
      ST_HOLD: if (OUT_READY)         state_nxt = ST_FILL;
      default: state_nxt = ST_FILL;
    endcase
  end

  // Output decode from state only; no input reaches IN_READY or OUT_VALID.
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      ST_FILL: in_ready_c  = 1'b1;
      ST_HOLD: out_valid_c = 1'b1;
      default: in_ready_c  = 1'b0;
    endcase
  end

  assign IN_READY  = in_ready_c;
  assign OUT_VALID = out_valid_c;

  // Word counter over the frame; wraps on the last word.
  always_comb begin
    cnt_nxt = cnt;
    if (xfer) begin
      if (last_word) begin
        cnt_nxt = '0;
      end else if (skip_key) begin
        cnt_nxt = CNT_W'(WPF + 1);
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Upper counter bits select the field receiving the current word.
  assign fld_sel = skip_key ? 2'(FLD_N) : 2'(cnt >> SEL_SH);

  for (genvar i = 0; i < NUM_FLD; i++) begin : g_fld
    assign fld_en[i] = xfer && (fld_sel == 2'(i));

    ascon_field_shreg #(
      .BUS_W (BUS_W)
    ) u_shreg (
      .clk (CLK),
      .rst (RST),
      .en  (fld_en[i]),
      .din (DIN),
      .q   (fld_q[i])
    );
  end

  assign SK_OUT = fld_q[FLD_SK];
  assign N_OUT  = fld_q[FLD_N];
  assign A_OUT  = fld_q[FLD_A];
  assign P_OUT  = fld_q[FLD_P];

endmodule

// File: tb/tb_ascon_in_loader.sv
// Directed testbench for ascon_in_loader: a BUS_W=32 instance and a
// BUS_W=128 instance sharing clock and reset. Key-reuse scenarios run
// when ASCON_LOADER_KEY_REUSE_EN is defined.
module tb_ascon_in_loader;

  logic         clk;
  logic         rst;
  logic [31:0]  din;
  logic         in_valid;
  logic         in_ready;
  logic         key_keep;
  logic [127:0] sk_out, n_out, a_out, p_out;
  logic         out_valid;
  logic         out_ready;

  logic [127:0] din128;
  logic         iv128, ir128;
  logic [127:0] sk128, n128, a128, p128;
  logic         ov128, or128;

  int n_checks;
  int n_pass;

  ascon_in_loader #(.BUS_W(32)) u_dut (
    .CLK       (clk),
    .RST       (rst),
    .DIN       (din),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
`ifdef ASCON_LOADER_KEY_REUSE_EN
    .KEY_KEEP  (key_keep),
`endif
    .SK_OUT    (sk_out),
    .N_OUT     (n_out),
    .A_OUT     (a_out),
    .P_OUT     (p_out),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready)
  );

  ascon_in_loader #(.BUS_W(128)) u_dut128 (
    .CLK       (clk),
    .RST       (rst),
    .DIN       (din128),
    .IN_VALID  (iv128),
    .IN_READY  (ir128),
`ifdef ASCON_LOADER_KEY_REUSE_EN
    .KEY_KEEP  (key_keep),
`endif
    .SK_OUT    (sk128),
    .N_OUT     (n128),
    .A_OUT     (a128),
    .P_OUT     (p128),
    .OUT_VALID (ov128),
    .OUT_READY (or128)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mk4(input logic [31:0] b);
    return {b, b + 32'd1, b + 32'd2, b + 32'd3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted word on the 32-bit instance.
  task automatic drive_word(input logic [31:0] w, input logic kk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL in_ready_fill: got %b want 1", in_ready);
    else n_pass++;
    din = w;
    in_valid = 1'b1;
    key_keep = kk;
    step();
    in_valid = 1'b0;
    key_keep = 1'b0;
  endtask

  task automatic drive_seq(input logic [31:0] base, input int n, input logic kk_first);
    for (int i = 0; i < n; i++) begin
      drive_word(base + 32'(i), (i == 0) ? kk_first : 1'b0);
    end
  endtask

  task automatic release_frame();
    out_ready = 1'b1;
    or128 = 1'b1;
    step();
    out_ready = 1'b0;
    or128 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    n_checks++;
    if ({sk_out, n_out, a_out, p_out} !== '0) $display("FAIL reset_fields: got %h want 0", {sk_out, n_out, a_out, p_out});
    else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
    else n_pass++;
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || ir128 !== 1'b1) $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready, ir128);
    else n_pass++;
  endtask

  task automatic test_basic();
    drive_seq(32'h0, 15, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid);
    else n_pass++;
    drive_word(32'hF, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL basic_latency: got ov=%b ir=%b want 1/0", out_valid, in_ready);
    else n_pass++;
    n_checks++;
    if (sk_out !== 128'h00000000_00000001_00000002_00000003) $display("FAIL basic_sk: got %h", sk_out);
    else n_pass++;
    n_checks++;
    if (n_out !== mk4(32'h4) || a_out !== mk4(32'h8)) $display("FAIL basic_n_a: got %h %h", n_out, a_out);
    else n_pass++;
    n_checks++;
    if (p_out !== 128'h0000000C_0000000D_0000000E_0000000F) $display("FAIL basic_p: got %h", p_out);
    else n_pass++;
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL hold_hs cyc %0d: got ov=%b ir=%b want 1/0", i, out_valid, in_ready);
      else n_pass++;
      n_checks++;
      if (sk_out !== mk4(32'h0) || p_out !== mk4(32'hC)) $display("FAIL hold_fields cyc %0d: got %h %h", i, sk_out, p_out);
      else n_pass++;
    end
    release_frame();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL hold_release: got ov=%b ir=%b want 0/1", out_valid, in_ready);
    else n_pass++;
    n_checks++;
    if (a_out !== mk4(32'h8)) $display("FAIL fill_retain: got %h want %h", a_out, mk4(32'h8));
    else n_pass++;
  endtask

  task automatic test_midframe_reset();
    drive_seq(32'h0, 10, 1'b0);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({sk_out, n_out, a_out, p_out} !== '0 || out_valid !== 1'b0) $display("FAIL mid_reset_zero: got sk=%h ov=%b", sk_out, out_valid);
    else n_pass++;
    step();
    rst = 1'b0;
    step();
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL mid_reset_ready: got %b want 1", in_ready);
    else n_pass++;
    drive_seq(32'h20, 16, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL fresh_valid: got %b want 1", out_valid);
    else n_pass++;
    n_checks++;
    if (sk_out !== mk4(32'h20) || n_out !== mk4(32'h24) || a_out !== mk4(32'h28) || p_out !== mk4(32'h2C))
      $display("FAIL fresh_fields: got %h %h %h %h", sk_out, n_out, a_out, p_out);
    else n_pass++;
    release_frame();
  endtask

  // IN_VALID toggled every other cycle; OUT_READY high during fill must be ignored.
  task automatic test_stall();
    int edges;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    edges = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL stall_early_valid: got %b want 0 after %0d cycles", out_valid, edges);
        else n_pass++;
      end
      drive_word(32'(i), 1'b0);
      edges++;
      if (i < 15) begin
        din = 32'hDEAD_BEEF;
        in_valid = 1'b0;
        step();
        edges++;
      end
    end
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1 after %0d cycles", out_valid, edges);
    else n_pass++;
    n_checks++;
    if (sk_out !== mk4(32'h0) || n_out !== mk4(32'h4) || a_out !== mk4(32'h8) || p_out !== mk4(32'hC))
      $display("FAIL stall_fields: got %h %h %h %h", sk_out, n_out, a_out, p_out);
    else n_pass++;
    release_frame();
  endtask

  task automatic test_bus128();
    logic [127:0] w [4];
    w[0] = 128'h0123456789ABCDEF_FEDCBA9876543210;
    w[1] = 128'hA5A5A5A5_5A5A5A5A_00FF00FF_FF00FF00;
    w[2] = 128'h11112222_33334444_55556666_77778888;
    w[3] = 128'hCAFEBABE_DEADBEEF_0BADF00D_12345678;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        n_checks++;
        if (ov128 !== 1'b0) $display("FAIL b128_early_valid: got %b want 0", ov128);
        else n_pass++;
      end
      din128 = w[i];
      iv128 = 1'b1;
      step();
    end
    iv128 = 1'b0;
    n_checks++;
    if (ov128 !== 1'b1 || ir128 !== 1'b0) $display("FAIL b128_valid: got ov=%b ir=%b want 1/0", ov128, ir128);
    else n_pass++;
    n_checks++;
    if (sk128 !== w[0] || n128 !== w[1] || a128 !== w[2] || p128 !== w[3])
      $display("FAIL b128_fields: got %h %h %h %h", sk128, n128, a128, p128);
    else n_pass++;
    release_frame();
    n_checks++;
    if (ov128 !== 1'b0 || ir128 !== 1'b1) $display("FAIL b128_release: got ov=%b ir=%b want 0/1", ov128, ir128);
    else n_pass++;
  endtask

`ifdef ASCON_LOADER_KEY_REUSE_EN
  task automatic test_key_reuse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    for (int i = 0; i < 4; i++) drive_word(32'h1111_1111, 1'b0);
    drive_seq(32'h30, 12, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || sk_out !== {4{32'h1111_1111}}) $display("FAIL kr_frame1: got ov=%b sk=%h", out_valid, sk_out);
    else n_pass++;
    release_frame();
    drive_seq(32'h40, 11, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL kr_early_valid: got %b want 0", out_valid);
    else n_pass++;
    drive_word(32'h4B, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL kr_valid12: got %b want 1", out_valid);
    else n_pass++;
    n_checks++;
    if (sk_out !== {4{32'h1111_1111}} || n_out !== mk4(32'h40) || a_out !== mk4(32'h44) || p_out !== mk4(32'h48))
      $display("FAIL kr_fields: got %h %h %h %h", sk_out, n_out, a_out, p_out);
    else n_pass++;
    release_frame();
    // KEY_KEEP right after reset must be ignored: full frame required.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    step();
    drive_seq(32'h50, 12, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL kr_nokey_valid12: got %b want 0", out_valid);
    else n_pass++;
    drive_seq(32'h5C, 4, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || sk_out !== mk4(32'h50) || p_out !== mk4(32'h5C))
      $display("FAIL kr_nokey_full: got ov=%b sk=%h p=%h", out_valid, sk_out, p_out);
    else n_pass++;
    release_frame();
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    din       = '0;
    in_valid  = 1'b0;
    key_keep  = 1'b0;
    out_ready = 1'b0;
    din128    = '0;
    iv128     = 1'b0;
    or128     = 1'b0;

    test_reset();
    test_basic();
    test_hold();
    test_midframe_reset();
    test_stall();
    test_bus128();
`ifdef ASCON_LOADER_KEY_REUSE_EN
    test_key_reuse();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
